// File: rtl/delay_scheduler.sv
// delay_scheduler: queues delay requests and issues them in order to a start/value/done delay counter.
// Optional watchdog on a stalled counter is enabled by defining DELAY_SCHED_TIMEOUT_EN.
module delay_scheduler #(
  parameter int DEPTH          = 4,
  parameter int VALUE_W        = 32,
  parameter int TAG_W          = 8,
  parameter int TIMEOUT_MARGIN = 4
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [VALUE_W-1:0]       i_req_value,
  input  logic [TAG_W-1:0]         i_req_tag,
  output logic                     o_dly_start,
  output logic [VALUE_W-1:0]       o_dly_value,
  input  logic                     i_dly_done,
  output logic                     o_cpl_valid,
  output logic [TAG_W-1:0]         o_cpl_tag,
  output logic                     o_cpl_err,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_busy
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t r_state, w_next;
  logic [VALUE_W-1:0] r_val_mem [DEPTH];
  logic [TAG_W-1:0] r_tag_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count;
  logic [VALUE_W-1:0] r_dly_value;
  logic [TAG_W-1:0] r_tag, r_cpl_tag;
  logic r_cpl_valid, r_cpl_err;
  logic w_empty, w_push, w_pop, w_err, w_fin;
  assign w_empty = r_count == '0;
  assign o_req_ready = r_count != (AW+1)'(DEPTH);
  assign w_push = i_req_valid && o_req_ready;
  // an empty FIFO forwards the incoming request straight into the active slot
  assign w_pop = r_state == IDLE && (!w_empty || w_push);
  assign w_fin = r_state == WAIT && (i_dly_done || w_err);
  assign o_dly_start = r_state == ISSUE;
  assign o_dly_value = r_dly_value;
  assign o_cpl_valid = r_cpl_valid;
  assign o_cpl_tag = r_cpl_tag;
  assign o_cpl_err = r_cpl_err;
  assign o_count = r_count;
  assign o_busy = r_state != IDLE || !w_empty;
`ifdef DELAY_SCHED_TIMEOUT_EN
  logic [VALUE_W:0] r_wait_cnt;
  assign w_err = r_state == WAIT && !i_dly_done &&
                 r_wait_cnt == {1'b0, r_dly_value} + (VALUE_W+1)'(TIMEOUT_MARGIN);
  always_ff @(posedge i_clock)
    if (r_state == ISSUE) r_wait_cnt <= '0;
    else if (!(&r_wait_cnt)) r_wait_cnt <= r_wait_cnt + (VALUE_W+1)'(1);
`else
  assign w_err = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_pop ? ISSUE : IDLE;
      ISSUE:   w_next = WAIT;
      WAIT:    w_next = w_fin ? IDLE : WAIT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clock)
    if (w_push) begin
      r_val_mem[r_wr] <= i_req_value;
      r_tag_mem[r_wr] <= i_req_tag;
    end
  always_ff @(posedge i_clock)
    if (!i_reset) begin
      r_state <= IDLE;
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
      r_dly_value <= '0;
      r_tag <= '0;
      r_cpl_valid <= 1'b0;
      r_cpl_tag <= '0;
      r_cpl_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) begin
        r_rd <= r_rd + AW'(1);
        r_dly_value <= w_empty ? i_req_value : r_val_mem[r_rd];
        r_tag <= w_empty ? i_req_tag : r_tag_mem[r_rd];
      end
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_cpl_valid <= w_fin;
      if (w_fin) begin
        r_cpl_tag <= r_tag;
        r_cpl_err <= w_err;
      end
    end
endmodule
